// File: rtl/uart_frame_feeder_if.sv
// Handshake bundle between the frame feeder, its requester and the 8N1 byte transmitter.
// The master view belongs to the feeder; the slave view is the surrounding environment.
`timescale 1ns/1ps
interface uart_frame_feeder_if;
    logic        send_req;
    logic [31:0] freq_word;
    logic        ready;
    logic        frame_done;
    logic        frame_err;
    logic [7:0]  uart_data;
    logic        uart_tx_en;
    logic        uart_tx_busy;

    modport master (
        input  send_req, freq_word, uart_tx_busy,
        output ready, frame_done, frame_err, uart_data, uart_tx_en
    );

    modport slave (
        output send_req, freq_word, uart_tx_busy,
        input  ready, frame_done, frame_err, uart_data, uart_tx_en
    );
endinterface

// File: rtl/uart_frame_feeder.sv
// Formats a captured 32-bit DDS word as "<TAG>=XXXXXXXX\r\n" and paces it byte by byte
// into an 8N1 transmitter using the transmitter's enable edge and busy flag.
`timescale 1ns/1ps
module uart_frame_feeder #(
    parameter logic [7:0] CHAR_TAG     = 8'h46,
    parameter int         BUSY_TIMEOUT = 16
) (
    input logic                 clk,
    input logic                 rst,
    uart_frame_feeder_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [4:0] TMO_LAST = 5'(BUSY_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  idx_q, idx_d;
    logic [4:0]  tmo_q, tmo_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        en_q, en_d;
    logic [7:0]  data_q, data_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Frame positions 2..9 carry the word's nibbles, most significant first.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [31:0] w);
        logic [2:0] nib_sel;
        nib_sel = 3'(4'd9 - idx);
        case (idx)
            4'd0:    frame_byte = CHAR_TAG;
            4'd1:    frame_byte = 8'h3D;
            4'd10:   frame_byte = 8'h0D;
            4'd11:   frame_byte = 8'h0A;
            default: frame_byte = hex_char(w[{nib_sel, 2'b00} +: 4]);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= 32'h0;
            idx_q   <= 4'd0;
            tmo_q   <= 5'd0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            data_q  <= data_d;
        end
    end

    // A busy flag still high on entry to WAIT_DONE belongs to the byte just started.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        en_d    = en_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (bus.send_req) begin
                    word_d  = bus.freq_word;
                    idx_d   = 4'd0;
                    data_d  = CHAR_TAG;
                    en_d    = 1'b1;
                    ready_d = 1'b0;
                    tmo_d   = 5'd0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                tmo_d = tmo_q + 5'd1;
                if (bus.uart_tx_busy) begin
                    en_d    = 1'b0;
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    if (idx_q == 4'd11) begin
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        data_d  = frame_byte(idx_q + 4'd1, word_q);
                        en_d    = 1'b1;
                        tmo_d   = 5'd0;
                        state_d = WAIT_BUSY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready      = ready_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.uart_data  = data_q;
    assign bus.uart_tx_en = en_q;

endmodule
